// File: rtl/ripple_count_tracker.sv
// Purpose: filter a 4-bit ripple-counter code into clk, accept only stable codes, extend to WIDTH bits.
// Latency: a code held on cq_in from before edge k is acted on at edge k+2 (registered outputs, 3 edges).
// Backpressure: none; the upstream counter free-runs and each accepted code is consumed once.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   cq_in             raw ripple-counter value, asynchronous to clk
//   en                count enable (codes are still tracked when low)
//   clear             synchronous clear of count, flags and seed
//   thresh            compare value for thresh_hit
//   cnt_out           extended accepted count (WIDTH legal range 5..16)
//   step_pulse        one-cycle pulse per accepted +1 step
//   wrap_pulse        one-cycle pulse on an accepted 15->0 step
//   thresh_hit        sticky, set when cnt_out becomes equal to thresh
//   glitch_err        sticky, set on any accepted non-+1 change
module ripple_count_tracker #(
    parameter int WIDTH          = 8,
    parameter bit STOP_AT_THRESH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cq_in,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] thresh,
    output logic [WIDTH-1:0] cnt_out,
    output logic             step_pulse,
    output logic             wrap_pulse,
    output logic             thresh_hit,
    output logic             glitch_err
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       last_q;
    logic [3:0]       last_d;
    logic [3:0]       delta;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_inc;
    logic             step_d;
    logic             wrap_d;
    logic             hit_d;
    logic             glitch_d;
    logic             stable;
    logic             accept;

    // Two equal consecutive samples mean the ripple chain has settled.
    assign stable  = (s1 == s2);
    assign accept  = stable && (s2 != last_q);
    // 4-bit subtraction gives the modulo-16 step, so 15->0 reads as +1.
    assign delta   = s2 - last_q;
    assign cnt_inc = cnt_out + {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_out;
        step_d   = 1'b0;
        wrap_d   = 1'b0;
        hit_d    = thresh_hit;
        glitch_d = glitch_err;

        if (clear) begin
            state_d  = ST_INIT;
            cnt_d    = '0;
            hit_d    = 1'b0;
            glitch_d = 1'b0;
        end else begin
            case (state_q)
                // Seed from the first stable pair; straight out of reset
                // that pair is the zeroed sampler itself.
                ST_INIT: begin
                    if (stable) begin
                        last_d  = s2;
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (accept) begin
                        last_d = s2;
                        if (delta != 4'd1) begin
                            glitch_d = 1'b1;
                        end else if (en) begin
                            cnt_d  = cnt_inc;
                            step_d = 1'b1;
                            wrap_d = (last_q == 4'hF);
                            if (cnt_inc == thresh) begin
                                hit_d = 1'b1;
                                if (STOP_AT_THRESH) begin
                                    state_d = ST_HOLD;
                                end
                            end
                        end
                    end
                end
                // Count frozen; keep following the code so a later clear
                // reseeds from a fresh stable value anyway.
                ST_HOLD: begin
                    if (accept) begin
                        last_d = s2;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= 4'd0;
            s2         <= 4'd0;
            last_q     <= 4'd0;
            state_q    <= ST_INIT;
            cnt_out    <= '0;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            thresh_hit <= 1'b0;
            glitch_err <= 1'b0;
        end else begin
            s1         <= cq_in;
            s2         <= s1;
            last_q     <= last_d;
            state_q    <= state_d;
            cnt_out    <= cnt_d;
            step_pulse <= step_d;
            wrap_pulse <= wrap_d;
            thresh_hit <= hit_d;
            glitch_err <= glitch_d;
        end
    end

endmodule
